ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) from the host to the keyboard over the open-drain PS/2 clock/data pair, then checks the device acknowledge. It is the write direction for the same PS/2 port whose receive side decodes scancodes for the display path. It shares the `ps2_clk`/`ps2_data` pads with that receiver via external open-drain buffers.

## Interface

**Parameters**
- `INHIBIT_CYCLES`, default 5000: `clk` cycles the clock line is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum `clk` cycles from clock release to frame end (15 ms at 50 MHz).

**Ports**
- `clk`  in  1: system clock.
- `clrn`  in  1: asynchronous, active-low reset.
- `din`  in  8: byte to send; sampled when `start` is accepted.
- `start`  in  1: request; accepted only in IDLE.
- `busy`  out  1: high from the cycle after acceptance until return to IDLE.
- `done`  out  1: one-cycle pulse on normal frame end.
- `ack_err`  out  1: valid with `done`; 1 = device did not pull data low on the ack edge.
- `timeout_err`  out  1: one-cycle pulse on timeout; `done` is not pulsed.
- `ps2_clk_i`  in  1: clock line level.
- `ps2_data_i`  in  1: data line level.
- `ps2_clk_low`  out  1: 1 = drive clock line low, 0 = release.
- `ps2_data_low`  out  1: 1 = drive data line low, 0 = release.

## Operation

- **Input sync:** `ps2_clk_i` and `ps2_data_i` each pass through a 3-flop shift register. A falling edge is detected when stage2=1 and stage1=0.
- **Reset:** all outputs are registered and reset to 0 (both lines released), state = IDLE, all counters = 0.
- **IDLE**
  - On `start`: latch `din` into the shift register.
  - Latch `parity = ~^din` (odd parity).
  - Go to INHIBIT.
- **INHIBIT**
  - `ps2_clk_low`=1, `ps2_data_low`=0.
  - Count `INHIBIT_CYCLES` cycles, then go to REQ.
- **REQ** (one cycle)
  - `ps2_clk_low`=1, `ps2_data_low`=1; this is the start bit.
  - Then go to SEND and clear `edge_cnt`.
- **SEND**
  - `ps2_clk_low`=0 (released).
  - On each detected falling edge, increment `edge_cnt` (4 bits) and set data for the new bit:
    - edges 1–8: `ps2_data_low = ~d[edge-1]`, LSB first;
    - edge 9: `ps2_data_low = ~parity`;
    - edge 10: `ps2_data_low`=0 (stop bit, released); go to ACK.
- **ACK**
  - On the next falling edge, sample synced data: `ack_err` = synced data level (0 = acked).
  - Go to WAIT_IDLE.
- **WAIT_IDLE**
  - When synced clock=1 and synced data=1, pulse `done` (with `ack_err` held that cycle) and go to IDLE.
- **Timeout counter**
  - Cleared on entering SEND; counts in SEND, ACK and WAIT_IDLE.
  - On reaching `TIMEOUT_CYCLES`: release both lines, pulse `timeout_err`, go to IDLE.
  - A timeout in the same cycle as a falling edge wins.
- **Busy handling:** `start` while `busy` is ignored; `din` changes after acceptance have no effect.
- **Reset mid-frame:** lines are released immediately (asynchronously); no `done` or `timeout_err` pulse.

## Timing

- **Start:** `start` sampled at cycle T → `busy`=1 and `ps2_clk_low`=1 at T+1.
- **Request:**
  - Clock-only low for exactly `INHIBIT_CYCLES` cycles (T+1 … T+INHIBIT_CYCLES).
  - Both lines low at T+INHIBIT_CYCLES+1.
  - Clock released, data still low from T+INHIBIT_CYCLES+2.
- **Data update:** a pad falling edge appears on the edge-detect 2–3 cycles later; `ps2_data_low` updates on the cycle after detection. This is well within the device's ≥5 µs low phase.
- **Frame:** 11 device falling edges per frame (10 in SEND, 1 in ACK).
- **Completion:** `done`/`timeout_err` are high for exactly one cycle; `busy` falls on the same cycle. A new `start` is accepted on the following cycle.
- **Error flags:** `ack_err` is meaningful only while `done`=1 and is 0 otherwise.

## Test plan

Run with `INHIBIT_CYCLES`=8 and `TIMEOUT_CYCLES`=2000, against a bench device model clocking at a 40-cycle period.

1. **Normal send:** `din`=0xED → data bits sampled on device rising edges are 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1; device acks → `done` pulse, `ack_err`=0, `busy` falls the same cycle.
2. **Parity:** `din`=0x01 → parity bit 0; `din`=0xFF → parity bit 1. The clock-low phase lasts exactly 8 cycles, followed by one cycle with both lines low.
3. **Missing ack:** device leaves data high on the 11th edge → `done`=1 with `ack_err`=1.
4. **Dead device:** device never clocks → `timeout_err` pulses exactly 2000 cycles after clock release; both lines released; `busy`=0; `done` never pulses.
5. **Reset mid-frame:** assert `clrn`=0 after the 4th edge → `ps2_clk_low`=`ps2_data_low`=0 and `busy`=0 asynchronously; the next `start` sends a clean frame.
6. **Ignored start:** pulse `start` with `din`=0xAA during a frame of 0xF3 → only 0xF3 is sent. A back-to-back `start` the cycle after `done` is accepted.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte plus odd parity and stop out on device clock edges, then checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] din,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_low,
  output logic       ps2_data_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [2:0]       clk_sync;
  logic [2:0]       data_sync;
  logic [7:0]       shreg;
  logic             parity;
  logic [3:0]       edge_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ack_bit;

  logic clk_fall;
  logic clk_level;
  logic data_level;
  logic in_frame;
  logic tmo_hit;

  // Stage 1 is the newest synchronised sample; a fall is old-high, new-low.
  assign clk_fall   = clk_sync[2] & ~clk_sync[1];
  assign clk_level  = clk_sync[1];
  assign data_level = data_sync[1];
  assign in_frame   = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign tmo_hit    = in_frame && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state        <= IDLE;
      clk_sync     <= 3'b111;
      data_sync    <= 3'b111;
      shreg        <= '0;
      parity       <= 1'b0;
      edge_cnt     <= '0;
      inh_cnt      <= '0;
      tmo_cnt      <= '0;
      ack_bit      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ack_err      <= 1'b0;
      timeout_err  <= 1'b0;
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[1:0], ps2_clk_i};
      data_sync   <= {data_sync[1:0], ps2_data_i};
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;

      // A stuck or absent device must never wedge the port, so timeout outranks edges.
      if (tmo_hit) begin
        ps2_clk_low  <= 1'b0;
        ps2_data_low <= 1'b0;
        busy         <= 1'b0;
        timeout_err  <= 1'b1;
        state        <= IDLE;
      end else begin
        if (in_frame) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end

        case (state)
          IDLE: begin
            if (start) begin
              shreg        <= din;
              parity       <= ~^din;
              busy         <= 1'b1;
              ps2_clk_low  <= 1'b1;
              ps2_data_low <= 1'b0;
              inh_cnt      <= '0;
              state        <= INHIBIT;
            end
          end

          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_low <= 1'b1;
              state        <= REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end

          REQ: begin
            ps2_clk_low <= 1'b0;
            edge_cnt    <= '0;
            tmo_cnt     <= '0;
            state       <= SEND;
          end

          SEND: begin
            if (clk_fall) begin
              edge_cnt <= edge_cnt + 4'd1;
              if (edge_cnt < 4'd8) begin
                ps2_data_low <= ~shreg[0];
                shreg        <= {1'b0, shreg[7:1]};
              end else if (edge_cnt == 4'd8) begin
                ps2_data_low <= ~parity;
              end else begin
                ps2_data_low <= 1'b0;
                state        <= ACK;
              end
            end
          end

          ACK: begin
            if (clk_fall) begin
              ack_bit <= data_level;
              state   <= WAIT_IDLE;
            end
          end

          WAIT_IDLE: begin
            if (clk_level && data_level) begin
              done    <= 1'b1;
              ack_err <= ack_bit;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end

          default: begin
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and compares the captured bits against a frame built from the byte arithmetically.
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] din = 8'h00;
  logic       start = 1'b0;
  logic       busy, done, ack_err, timeout_err;
  logic       ps2_clk_low, ps2_data_low;
  logic       ps2_clk_i, ps2_data_i;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int total = 0;
  int passed = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;

  assign ps2_clk_i  = ~(ps2_clk_low | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .din(din),
    .start(start),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .timeout_err(timeout_err),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_low(ps2_clk_low),
    .ps2_data_low(ps2_data_low)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (timeout_err) tmo_cnt <= tmo_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line order as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((b >> i) & 8'd1) != 8'd0;
      if (f[i+1]) ones = ones + 1;
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Issues start at the current negedge and checks the inhibit/request shape;
  // returns on the first cycle with the clock released.
  task automatic request(input logic [7:0] b);
    int n;
    din   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din   = 8'($urandom);
    chk("busy_after_start", busy, 1);
    chk("clk_low_after_start", ps2_clk_low, 1);
    n = 0;
    while (ps2_clk_low && !ps2_data_low && n < 50) begin
      n = n + 1;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    chk("req_both_low", {ps2_clk_low, ps2_data_low}, 2'b11);
    @(negedge clk);
    chk("release_clk_data_low", {ps2_clk_low, ps2_data_low}, 2'b01);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input int abort_at, input bit inject);
    logic [10:0] got;
    bit seen;
    got = '0;
    request(b);
    repeat (20) @(negedge clk);
    got[0] = ps2_data_i;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (inject && i == 3) begin
        repeat (5) @(negedge clk);
        din   = 8'hAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
      end else if (abort_at == i) begin
        repeat (10) @(negedge clk);
        chk("pre_rst_data_low", ps2_data_low, {31'd0, ~b[i-1]});
        #2;
        clrn = 1'b0;
        #1;
        chk("rst_clk_low", ps2_clk_low, 0);
        chk("rst_data_low", ps2_data_low, 0);
        chk("rst_busy", busy, 0);
        dev_clk_low = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        return;
      end else begin
        repeat (20) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      got[i] = ps2_data_i;
      if (i == 10) begin
        repeat (10) @(negedge clk);
        if (ack) dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
    end
    $display("frame din=%02h sent=%03h expected=%03h ack=%0d", b, got, ref_frame(b), ack);
    chk("frame_bits", got, ref_frame(b));
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) dev_data_low = 1'b0;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    dev_data_low = 1'b0;
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("ack_err", ack_err, {31'd0, ~ack});
      chk("busy_at_done", busy, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("ack_err_idle", ack_err, 0);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, ack_err, timeout_err, ps2_clk_low, ps2_data_low}, 6'b0);
    clrn = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {busy, done, ack_err, timeout_err, ps2_clk_low, ps2_data_low}, 6'b0);

    run_frame(8'hED, 1'b1, 0, 1'b0);
    run_frame(8'h01, 1'b1, 0, 1'b0);
    run_frame(8'hFF, 1'b1, 0, 1'b0);
    run_frame(8'h5A, 1'b0, 0, 1'b0);

    // Dead device: nothing ever clocks after the request.
    request(8'h3C);
    k = 0;
    while (k < TMO + 100) begin
      k = k + 1;
      @(negedge clk);
      if (timeout_err) break;
    end
    $display("timeout after %0d cycles expected %0d", k, TMO);
    chk("timeout_cycles", k, TMO);
    chk("timeout_lines", {ps2_clk_low, ps2_data_low}, 2'b00);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_done", done, 0);
    @(negedge clk);
    chk("timeout_one_cycle", timeout_err, 0);

    run_frame(8'h00, 1'b1, 4, 1'b0);
    run_frame(8'hC3, 1'b1, 0, 1'b0);
    run_frame(8'hF3, 1'b1, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("done_total", done_cnt, 12);
    chk("timeout_total", tmo_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
